// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader controller.
// The optional UART_BOOT_CHECKSUM_EN build uses the POP_CHK/WAIT_CHK states and ERR_CHK.
package uart_boot_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_POP_HDR   = 4'd1,
        ST_WAIT_HDR  = 4'd2,
        ST_POP_DATA  = 4'd3,
        ST_WAIT_DATA = 4'd4,
        ST_WRITE     = 4'd5,
        ST_POP_CHK   = 4'd6,
        ST_WAIT_CHK  = 4'd7,
        ST_FINISH    = 4'd8,
        ST_DONE      = 4'd9,
        ST_ERR       = 4'd10
    } boot_state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_LEN  = 2'd2,
        ERR_CHK  = 2'd3
    } err_code_e;

    function automatic logic is_pop_state(input boot_state_e st);
        return (st == ST_POP_HDR) || (st == ST_POP_DATA) || (st == ST_POP_CHK);
    endfunction

endpackage

// File: rtl/uart_boot_loader_ctrl_xsum.sv
// Running XOR of payload words; match compares the accumulator with a trailer word.
// Instantiated by the top only when UART_BOOT_CHECKSUM_EN is defined.
module uart_boot_xsum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [31:0] cmp_word,
    output logic        match
);

    logic [31:0] acc_r;

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= 32'h0000_0000;
        end else if (clr) begin
            acc_r <= 32'h0000_0000;
        end else if (en) begin
            acc_r <= acc_r ^ data;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign match = (acc_r == cmp_word);

endmodule

// File: rtl/uart_boot_loader_ctrl.sv
// Boot loader: packs UART bytes through the FIFO, decodes a length header, writes payload to memory.
// Optional trailer checksum check is built when UART_BOOT_CHECKSUM_EN is defined.
module uart_boot_loader_ctrl
    import uart_boot_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                MAX_WORDS = 4096,
    parameter int                CNT_W     = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              fifo_wr_en,
    output logic [7:0]        fifo_wr_data,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [31:0]       fifo_data_out,
    input  logic              fifo_data_out_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    boot_state_e       state_r, state_nxt_s;
    err_code_e         err_code_r;
    logic [1:0]        byte_cnt_r;
    logic [CNT_W-1:0]  len_r, words_done_r, hdr_len_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              busy_r, done_r, err_r, cpu_hold_r;
    logic              start_s, pop_s, last_pop_s, ovf_s, len_bad_s, last_word_s, wr_acc_s;
    logic              xsum_match_s;

    assign fifo_wr_en   = rx_valid && !fifo_full;
    assign fifo_wr_data = rx_data;

    assign start_s     = boot_start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
    assign pop_s       = fifo_rd_en && !fifo_empty;
    assign last_pop_s  = pop_s && (byte_cnt_r == 2'(BYTES_PER_WORD - 1));
    assign ovf_s       = rx_valid && fifo_full && busy_r;
    assign hdr_len_s   = fifo_data_out[CNT_W-1:0];
    assign len_bad_s   = (hdr_len_s == {CNT_W{1'b0}}) || (hdr_len_s > CNT_W'(MAX_WORDS)) ||
                         (fifo_data_out[31:CNT_W] != {(32-CNT_W){1'b0}});
    assign last_word_s = ((words_done_r + CNT_W'(1)) == len_r);
    assign wr_acc_s    = (state_r == ST_WRITE) && mem_gnt;

`ifdef UART_BOOT_CHECKSUM_EN
    uart_boot_xsum u_xsum (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_s),
        .en       (wr_acc_s),
        .data     (mem_wdata_r),
        .cmp_word (fifo_data_out),
        .match    (xsum_match_s)
    );
`else
    assign xsum_match_s = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an overflow during a load wins over everything else
    always_comb begin
        state_nxt_s = state_r;
        if (ovf_s) begin
            state_nxt_s = ST_ERR;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (boot_start) state_nxt_s = ST_POP_HDR;
                    else            state_nxt_s = state_r;
                end
                ST_POP_HDR: begin
                    if (last_pop_s) state_nxt_s = ST_WAIT_HDR;
                    else            state_nxt_s = state_r;
                end
                ST_WAIT_HDR: begin
                    if (!fifo_data_out_valid) state_nxt_s = state_r;
                    else if (len_bad_s)       state_nxt_s = ST_ERR;
                    else                      state_nxt_s = ST_POP_DATA;
                end
                ST_POP_DATA: begin
                    if (last_pop_s) state_nxt_s = ST_WAIT_DATA;
                    else            state_nxt_s = state_r;
                end
                ST_WAIT_DATA: begin
                    if (fifo_data_out_valid) state_nxt_s = ST_WRITE;
                    else                     state_nxt_s = state_r;
                end
                ST_WRITE: begin
                    if (!mem_gnt)         state_nxt_s = state_r;
                    else if (!last_word_s) state_nxt_s = ST_POP_DATA;
`ifdef UART_BOOT_CHECKSUM_EN
                    else                  state_nxt_s = ST_POP_CHK;
`else
                    else                  state_nxt_s = ST_FINISH;
`endif
                end
                ST_POP_CHK: begin
                    if (last_pop_s) state_nxt_s = ST_WAIT_CHK;
                    else            state_nxt_s = state_r;
                end
                ST_WAIT_CHK: begin
                    if (!fifo_data_out_valid) state_nxt_s = state_r;
                    else if (xsum_match_s)    state_nxt_s = ST_FINISH;
                    else                      state_nxt_s = ST_ERR;
                end
                ST_FINISH: state_nxt_s = ST_DONE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM-decoded strobes
    always_comb begin
        fifo_rd_en = 1'b0;
        mem_req    = 1'b0;
        if (is_pop_state(state_r)) begin
            fifo_rd_en = !fifo_empty;
        end else if (state_r == ST_WRITE) begin
            mem_req = 1'b1;
        end else begin
            fifo_rd_en = 1'b0;
        end
    end

    // Datapath and sticky status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_r   <= 2'd0;
            len_r        <= {CNT_W{1'b0}};
            words_done_r <= {CNT_W{1'b0}};
            mem_addr_r   <= BASE_ADDR;
            mem_wdata_r  <= 32'h0000_0000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= ERR_NONE;
            cpu_hold_r   <= 1'b1;
        end else begin
            if (start_s) begin
                byte_cnt_r <= 2'd0;
            end else if (pop_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end

            if (ovf_s) begin
                err_r      <= 1'b1;
                err_code_r <= ERR_OVF;
                busy_r     <= 1'b0;
            end else if (start_s) begin
                done_r       <= 1'b0;
                err_r        <= 1'b0;
                err_code_r   <= ERR_NONE;
                busy_r       <= 1'b1;
                cpu_hold_r   <= 1'b1;
                mem_addr_r   <= BASE_ADDR;
                words_done_r <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    ST_WAIT_HDR: begin
                        if (fifo_data_out_valid) begin
                            len_r <= hdr_len_s;
                            if (len_bad_s) begin
                                err_r      <= 1'b1;
                                err_code_r <= ERR_LEN;
                                busy_r     <= 1'b0;
                            end
                        end
                    end
                    ST_WAIT_DATA: begin
                        if (fifo_data_out_valid) mem_wdata_r <= fifo_data_out;
                    end
                    ST_WRITE: begin
                        if (wr_acc_s) begin
                            mem_addr_r   <= mem_addr_r + ADDR_W'(BYTES_PER_WORD);
                            words_done_r <= words_done_r + CNT_W'(1);
                        end
                    end
                    ST_WAIT_CHK: begin
                        if (fifo_data_out_valid && !xsum_match_s) begin
                            err_r      <= 1'b1;
                            err_code_r <= ERR_CHK;
                            busy_r     <= 1'b0;
                        end
                    end
                    ST_FINISH: begin
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        cpu_hold_r <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign err_code  = err_code_r;
    assign cpu_hold  = cpu_hold_r;

endmodule
